register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of every register in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, minimum 2.
REQ-003 SHALL have parameter ZERO_X0, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching read ports.
REQ-005 SHALL derive AW = clog2(NREGS), index width; AW is not user-settable.
REQ-006 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port init_req  in  1  synchronous request to re-run the initialisation sequence.
REQ-009 SHALL have port RS1  in  AW  read port 1 register index.
REQ-010 SHALL have port RS2  in  AW  read port 2 register index.
REQ-011 SHALL have port RD  in  AW  write register index.
REQ-012 SHALL have port RegWrite  in  1  write enable.
REQ-013 SHALL have port WriteData  in  XLEN  write data.
REQ-014 SHALL have port ReadData1  out  XLEN  read port 1 data.
REQ-015 SHALL have port ReadData2  out  XLEN  read port 2 data.
REQ-016 SHALL have port ready  out  1  high when the file is initialised and accepts reads and writes.

Function
REQ-017 SHALL implement a two-state FSM, INIT and RUN, plus an AW-bit init counter cnt.
REQ-018 In INIT, each rising edge SHALL write Array[cnt] = cnt, zero-extended to XLEN, then increment cnt.
REQ-019 INIT SHALL go to RUN on the edge that writes index NREGS-1; ready SHALL be high from that edge onward, so INIT lasts exactly NREGS cycles.
REQ-020 In INIT, init_req and RegWrite SHALL be ignored and ReadData1/2 SHALL be 0.
REQ-021 In RUN, init_req=1 SHALL clear cnt, enter INIT, and drop ready on the next edge; a RegWrite in that cycle SHALL be dropped.
REQ-022 In RUN with init_req=0 and RegWrite=1, Array[RD] = WriteData SHALL be written on the rising edge, unless ZERO_X0=1 and RD=0.
REQ-023 Reads SHALL be combinational, with zero cycles of latency from RS1/RS2 to ReadData1/2.
REQ-024 Read priority SHALL be: (a) ready=0 gives 0; (b) ZERO_X0=1 and RSn=0 gives 0; (c) BYPASS=1, an eligible write in progress and RD=RSn gives WriteData; (d) otherwise Array[RSn].
REQ-025 With BYPASS=0, a read of RD in the write cycle SHALL return the old value; the new value SHALL be visible from the next cycle.
REQ-026 Both read ports SHALL be independent; RS1=RS2 SHALL return identical data.
REQ-027 The register array SHALL be clocked storage with a single write port; there SHALL be no latches and no combinational writes.

Reset
REQ-028 reset low SHALL immediately, without a clock, force state=INIT, cnt=0, ready=0, ReadData1/2=0.
REQ-029 The array SHALL NOT be asynchronously cleared; its contents are re-established by the INIT sequence after reset rises.
REQ-030 reset asserted mid-INIT or mid-RUN SHALL abort any operation in progress; the sequence restarts from cnt=0 on release.
REQ-031 After reset release with init_req=0 and no further reset, ready SHALL rise after exactly NREGS rising edges.

Verification
REQ-032 Reset release with defaults -> ready=0 for 32 edges, then ready=1; RS1=5, RS2=31 -> ReadData1=5, ReadData2=31.
REQ-033 RUN, RegWrite=1, RD=7, WriteData=64'hDEAD_BEEF_0000_0001, RS1=7 in the same cycle -> ReadData1 equals WriteData that cycle (BYPASS=1) and equals the old value 7 that cycle (BYPASS=0); both configurations read DEAD_BEEF_0000_0001 the next cycle.
REQ-034 RegWrite=1, RD=0, WriteData=all-ones, RS1=0 -> ReadData1=0 in the same cycle and the next cycle (ZERO_X0=1).
REQ-035 RUN: write reg 3 = 99, then pulse init_req with RegWrite=1 RD=4 -> ready low for 32 cycles, write to reg 4 dropped, then reg3=3 and reg4=4.
REQ-036 reset pulsed low at INIT cycle 10 -> ready and ReadData drop to 0 asynchronously; on release, a full 32-cycle INIT follows.
REQ-037 XLEN=32, NREGS=8 -> ready after 8 edges; reg 7 reads 32'h7; writes to all 8 indices read back correctly.

Source files
------------

// File: rtl/register_file_param.sv
// Parameterised register file with a self-initialising sequence.
// After reset, or on an init_req in RUN, every register i is loaded with the
// value i, one register per clock. ready goes high on the edge that loads the
// last register.
// Reads are combinational. An optional hard-wired zero register (x0) and
// optional write-to-read forwarding are selected by parameters.
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   reset      asynchronous active-low reset (FSM, counter, ready)
//   init_req   synchronous request to rerun initialisation (honoured in RUN)
//   RS1, RS2   read indices
//   RD         write index
//   RegWrite   write enable
//   WriteData  write data
//   ReadData1  read data, port 1 (combinational)
//   ReadData2  read data, port 2 (combinational)
//   ready      high once the file is initialised
module register_file_param #(
    parameter int unsigned  XLEN    = 64,
    parameter int unsigned  NREGS   = 32,
    parameter bit           ZERO_X0 = 1'b1,
    parameter bit           BYPASS  = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init_req,
    input  logic [AW-1:0]   RS1,
    input  logic [AW-1:0]   RS2,
    input  logic [AW-1:0]   RD,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            ready
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];

    logic            run_wr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    // A user write is eligible only in RUN. An init_req in the same cycle
    // drops it, and a write to x0 is discarded when x0 is hard-wired.
    always_comb begin
        run_wr = (state == RUN) && !init_req && RegWrite
                 && !(ZERO_X0 && (RD == '0));
    end

    // The single write port is owned by the init sequence in INIT and by the
    // user in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = RD;
        wr_data = WriteData;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = XLEN'(cnt);
        end else if (run_wr) begin
            wr_en = 1'b1;
        end
    end

    // Control FSM: INIT walks cnt across all registers; RUN waits for init_req.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(NREGS - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else if (init_req) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end
    end

    // The storage has no reset of its own. Writes are held off while reset is
    // low so that a reset cycle cannot disturb the contents.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port 1. The checks are in priority order: not ready, then x0,
    // then forwarding, then the array.
    always_comb begin
        ReadData1 = '0;
        if (!ready) begin
            ReadData1 = '0;
        end else if (ZERO_X0 && (RS1 == '0)) begin
            ReadData1 = '0;
        end else if (BYPASS && run_wr && (RD == RS1)) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs[RS1];
        end
    end

    // Read port 2, with the same priority order as port 1.
    always_comb begin
        ReadData2 = '0;
        if (!ready) begin
            ReadData2 = '0;
        end else if (ZERO_X0 && (RS2 == '0)) begin
            ReadData2 = '0;
        end else if (BYPASS && run_wr && (RD == RS2)) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs[RS2];
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param.
// It drives three instances from one clock and one reset:
//   dut_a  default parameters (64 x 32, x0 hard-wired, forwarding on)
//   dut_b  same as dut_a but without forwarding; shares dut_a's inputs
//   dut_c  32-bit x 8 registers, x0 writable, with its own inputs
// Expected values are queued when stimulus is applied and compared on the
// falling edge, one time unit after the inputs change.
module tb_register_file_param;

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0000_0001;

    localparam int A_RD1 = 0, A_RD2 = 1, A_RDY = 2;
    localparam int B_RD1 = 3, B_RD2 = 4, B_RDY = 5;
    localparam int C_RD1 = 6, C_RD2 = 7, C_RDY = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_req;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write;
    logic [63:0] wdata;
    logic [63:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_ready, b_ready;

    logic        c_init_req;
    logic [2:0]  c_rs1, c_rs2, c_rd;
    logic        c_we;
    logic [31:0] c_wd;
    logic [31:0] c_rd1, c_rd2;
    logic        c_ready;
    logic [31:0] c_model [8];

    typedef struct {
        string       tag;
        int          which;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_file_param dut_a (
        .clk(clk), .reset(reset), .init_req(init_req),
        .RS1(rs1), .RS2(rs2), .RD(rd), .RegWrite(reg_write), .WriteData(wdata),
        .ReadData1(a_rd1), .ReadData2(a_rd2), .ready(a_ready)
    );

    register_file_param #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .init_req(init_req),
        .RS1(rs1), .RS2(rs2), .RD(rd), .RegWrite(reg_write), .WriteData(wdata),
        .ReadData1(b_rd1), .ReadData2(b_rd2), .ready(b_ready)
    );

    register_file_param #(.XLEN(32), .NREGS(8), .ZERO_X0(1'b0)) dut_c (
        .clk(clk), .reset(reset), .init_req(c_init_req),
        .RS1(c_rs1), .RS2(c_rs2), .RD(c_rd), .RegWrite(c_we), .WriteData(c_wd),
        .ReadData1(c_rd1), .ReadData2(c_rd2), .ready(c_ready)
    );

    function automatic logic [63:0] observe(int which);
        case (which)
            A_RD1:   return a_rd1;
            A_RD2:   return a_rd2;
            A_RDY:   return 64'(a_ready);
            B_RD1:   return b_rd1;
            B_RD2:   return b_rd2;
            B_RDY:   return 64'(b_ready);
            C_RD1:   return 64'(c_rd1);
            C_RD2:   return 64'(c_rd2);
            C_RDY:   return 64'(c_ready);
            default: return 'x;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int which, input logic [63:0] exp);
        exp_t e;
        e.tag   = tag;
        e.which = which;
        e.exp   = exp;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.which);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic settle_check();
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; init_req = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        reg_write = 1'b0; wdata = '0;
        c_init_req = 1'b0; c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_we = 1'b0; c_wd = '0;

        // State while reset is held low
        repeat (3) @(negedge clk);
        rs1 = 5'd5;
        push_exp("rst_a_ready", A_RDY, 64'd0);
        push_exp("rst_b_ready", B_RDY, 64'd0);
        push_exp("rst_c_ready", C_RDY, 64'd0);
        push_exp("rst_a_rd1",   A_RD1, 64'd0);
        settle_check();

        // Release reset. The write requested during INIT must be ignored.
        @(negedge clk);
        reset = 1'b1; rs1 = 5'd5; rs2 = 5'd31;
        reg_write = 1'b1; rd = 5'd5; wdata = '1;
        c_rs1 = 3'd7;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            push_exp("init_a_ready", A_RDY, 64'd0);
            push_exp("init_b_ready", B_RDY, 64'd0);
            push_exp("init_a_rd1",   A_RD1, 64'd0);
            push_exp("init_a_rd2",   A_RD2, 64'd0);
            push_exp("init_c_ready", C_RDY, (k >= 8) ? 64'd1 : 64'd0);
            push_exp("init_c_rd1",   C_RD1, (k >= 8) ? 64'd7 : 64'd0);
            settle_check();
        end

        // After 32 edges: ready is high and registers hold their own index
        @(negedge clk);
        reg_write = 1'b0;
        push_exp("run_a_ready", A_RDY, 64'd1);
        push_exp("run_b_ready", B_RDY, 64'd1);
        push_exp("run_a_rd1_5", A_RD1, 64'd5);
        push_exp("run_a_rd2_31", A_RD2, 64'd31);
        push_exp("run_b_rd1_5", B_RD1, 64'd5);
        settle_check();

        // Same-cycle write and read of register 7
        @(negedge clk);
        rs1 = 5'd7; rs2 = 5'd7; rd = 5'd7; reg_write = 1'b1; wdata = DB;
        push_exp("byp_a_rd1", A_RD1, DB);
        push_exp("byp_a_rd2", A_RD2, DB);
        push_exp("nobyp_b_rd1", B_RD1, 64'd7);
        push_exp("nobyp_b_rd2", B_RD2, 64'd7);
        settle_check();

        @(negedge clk);
        reg_write = 1'b0;
        push_exp("after_a_rd1", A_RD1, DB);
        push_exp("after_b_rd1", B_RD1, DB);
        push_exp("after_b_rd2", B_RD2, DB);
        settle_check();

        // Writes to x0 are discarded and x0 always reads 0
        @(negedge clk);
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; reg_write = 1'b1; wdata = '1;
        push_exp("x0_a_rd1", A_RD1, 64'd0);
        push_exp("x0_a_rd2", A_RD2, 64'd0);
        push_exp("x0_b_rd1", B_RD1, 64'd0);
        settle_check();

        @(negedge clk);
        reg_write = 1'b0;
        push_exp("x0_next_a_rd1", A_RD1, 64'd0);
        push_exp("x0_next_b_rd1", B_RD1, 64'd0);
        settle_check();

        // Forwarding reaches only the port whose index matches RD
        @(negedge clk);
        rs1 = 5'd9; rs2 = 5'd8; rd = 5'd9; reg_write = 1'b1; wdata = 64'h0123_4567_89AB_CDEF;
        push_exp("w9_a_rd1", A_RD1, 64'h0123_4567_89AB_CDEF);
        push_exp("w9_a_rd2", A_RD2, 64'd8);
        push_exp("w9_b_rd1", B_RD1, 64'd9);
        settle_check();

        // Write register 3 = 99, then init_req together with a write that
        // must be dropped
        @(negedge clk);
        rs1 = 5'd3; rs2 = 5'd4; rd = 5'd3; reg_write = 1'b1; wdata = 64'd99;
        push_exp("w3_a_rd1", A_RD1, 64'd99);
        push_exp("w3_b_rd1", B_RD1, 64'd3);
        push_exp("w3_a_rd2", A_RD2, 64'd4);
        settle_check();

        @(negedge clk);
        init_req = 1'b1; rd = 5'd4; reg_write = 1'b1; wdata = 64'h1234;
        push_exp("ireq_a_rd1", A_RD1, 64'd99);
        push_exp("ireq_a_rd2_nobyp", A_RD2, 64'd4);
        push_exp("ireq_a_ready", A_RDY, 64'd1);
        settle_check();

        @(negedge clk);
        init_req = 1'b0; reg_write = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            push_exp("reinit_a_ready", A_RDY, 64'd0);
            push_exp("reinit_b_ready", B_RDY, 64'd0);
            push_exp("reinit_a_rd1",   A_RD1, 64'd0);
            push_exp("reinit_c_ready", C_RDY, 64'd1);
            settle_check();
        end

        @(negedge clk);
        push_exp("reinit_done_a_ready", A_RDY, 64'd1);
        push_exp("reinit_a_rd1_3", A_RD1, 64'd3);
        push_exp("reinit_a_rd2_4", A_RD2, 64'd4);
        push_exp("reinit_b_rd1_3", B_RD1, 64'd3);
        push_exp("reinit_b_rd2_4", B_RD2, 64'd4);
        settle_check();

        // Small configuration: write every index, then read back on both ports
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c_rd = 3'(i); c_rs1 = 3'(i); c_we = 1'b1;
            c_wd = 32'hC0DE_0000 + 32'(i * 17);
            c_model[i] = c_wd;
            push_exp("c_wr_byp", C_RD1, 64'(c_model[i]));
            settle_check();
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c_we = 1'b0; c_rs1 = 3'(i); c_rs2 = 3'(7 - i);
            push_exp("c_rb_rd1", C_RD1, 64'(c_model[i]));
            push_exp("c_rb_rd2", C_RD2, 64'(c_model[7 - i]));
            settle_check();
        end

        // Reset asserted mid-RUN clears ready and the read data without a clock
        @(negedge clk);
        rs1 = 5'd9; rs2 = 5'd9;
        push_exp("pre_rst_a_rd1", A_RD1, 64'd9);
        settle_check();
        #1 reset = 1'b0;
        push_exp("arst_run_a_ready", A_RDY, 64'd0);
        push_exp("arst_run_a_rd1",   A_RD1, 64'd0);
        push_exp("arst_run_b_rd1",   B_RD1, 64'd0);
        push_exp("arst_run_c_ready", C_RDY, 64'd0);
        settle_check();

        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            push_exp("init2_a_ready", A_RDY, 64'd0);
            settle_check();
        end

        // Reset asserted at INIT cycle 10
        @(negedge clk);
        #2 reset = 1'b0;
        push_exp("arst_init_a_ready", A_RDY, 64'd0);
        push_exp("arst_init_a_rd1",   A_RD1, 64'd0);
        settle_check();

        // A full 32-edge INIT follows release
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            push_exp("init3_a_ready", A_RDY, 64'd0);
            push_exp("init3_b_ready", B_RDY, 64'd0);
            settle_check();
        end

        @(negedge clk);
        push_exp("init3_done_a_ready", A_RDY, 64'd1);
        push_exp("init3_a_rd1_9", A_RD1, 64'd9);
        push_exp("init3_b_rd2_9", B_RD2, 64'd9);
        push_exp("init3_c_ready", C_RDY, 64'd1);
        settle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
